// File: rtl/npc_unit.sv
// Next-PC unit for the MIPS fetch stage: PC register, target selection, EPC capture
// and a one-entry buffer that holds a redirect arriving while fetch is stalled.
module npc_unit #(
  parameter int unsigned AW         = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter int unsigned PC_STEP    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic [2:0]    npcop,
  input  logic [AW-1:0] pcplusD,
  input  logic [15:0]   offset,
  input  logic [AW-1:0] absaddress,
  input  logic [AW-1:0] exc_pc,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pcplus,
  output logic [AW-1:0] epc,
  output logic          pend_valid,
  output logic          addr_err
);

  localparam logic [AW-1:0] RST_PC = AW'(RESET_PC);
  localparam logic [AW-1:0] EXC_PC = AW'(EXC_VECTOR);
  localparam logic [AW-1:0] STEP   = AW'(PC_STEP);
  localparam logic [AW-1:0] WORD   = AW'(4);

  localparam logic [2:0] OP_BR   = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_EXC  = 3'b011;
  localparam logic [2:0] OP_ERET = 3'b100;

  typedef enum logic {IDLE, HELD} pend_state_t;

  pend_state_t   state;
  logic [AW-1:0] pend_target;
  logic          pend_exc;

  logic [AW-1:0] target_raw;
  logic [AW-1:0] target;
  logic [AW-1:0] fault_epc;
  logic [AW-1:0] br_disp;
  logic          redirect;
  logic          misaligned;
  logic          redirect_exc;

  assign pcplus     = pc + STEP;
  assign pend_valid = (state == HELD);
  assign br_disp    = AW'($signed({offset, 2'b00}));

  // Raw redirect target for the current npcop; undefined codes fall back to sequential
  always_comb begin
    target_raw = pcplus;
    redirect   = 1'b0;
    case (npcop)
      OP_BR: begin
        target_raw = pcplusD + br_disp;
        redirect   = 1'b1;
      end
      OP_JMP: begin
        target_raw = absaddress;
        redirect   = 1'b1;
      end
      OP_EXC: begin
        target_raw = EXC_PC;
        redirect   = 1'b1;
      end
      OP_ERET: begin
        target_raw = epc;
        redirect   = 1'b1;
      end
      default: begin
        target_raw = pcplus;
        redirect   = 1'b0;
      end
    endcase
  end

  // Misaligned branch/jump targets become an exception that faults the instruction in D
  assign misaligned   = ((npcop == OP_BR) || (npcop == OP_JMP)) && (target_raw[1:0] != 2'b00);
  assign target       = misaligned ? EXC_PC : target_raw;
  assign redirect_exc = (npcop == OP_EXC) || misaligned;
  assign fault_epc    = misaligned ? (pcplusD - WORD) : exc_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RST_PC;
      epc         <= '0;
      pend_target <= '0;
      pend_exc    <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!stall) begin
            pc <= redirect ? target : pcplus;
            if (redirect_exc) begin
              epc      <= fault_epc;
              addr_err <= misaligned;
            end
          end else if (redirect) begin
            state       <= HELD;
            pend_target <= target;
            pend_exc    <= redirect_exc;
            if (redirect_exc) begin
              epc      <= fault_epc;
              addr_err <= misaligned;
            end
          end
        end
        HELD: begin
          // On release only a fresh exception can pre-empt the buffered target
          if (!stall) begin
            state <= IDLE;
            if (npcop == OP_EXC) begin
              pc  <= EXC_PC;
              epc <= exc_pc;
            end else begin
              pc <= pend_target;
            end
          end else if (redirect && (!pend_exc || redirect_exc)) begin
            pend_target <= target;
            pend_exc    <= redirect_exc;
            if (redirect_exc) begin
              epc      <= fault_epc;
              addr_err <= misaligned;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npc_unit.sv
// Scoreboard bench for npc_unit: a behavioural model queues the expected state per edge,
// which is popped and compared after the edge; directed scenarios add literal checks.
module tb_npc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [2:0]  npcop;
  logic [31:0] pcplusD;
  logic [15:0] offset;
  logic [31:0] absaddress;
  logic [31:0] exc_pc;
  logic [31:0] pc;
  logic [31:0] pcplus;
  logic [31:0] epc;
  logic        pend_valid;
  logic        addr_err;

  npc_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .npcop      (npcop),
    .pcplusD    (pcplusD),
    .offset     (offset),
    .absaddress (absaddress),
    .exc_pc     (exc_pc),
    .pc         (pc),
    .pcplus     (pcplus),
    .epc        (epc),
    .pend_valid (pend_valid),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        pv;
    logic        ae;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // model state
  logic [31:0] m_pc, m_epc, m_pt;
  logic        m_pv, m_pexc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h3000; m_epc = 32'h0; m_pt = 32'h0; m_pv = 1'b0; m_pexc = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic [2:0] op, input logic [31:0] pd,
                            input logic [15:0] off, input logic [31:0] ab, input logic [31:0] ep,
                            output logic ae);
    logic [31:0] tgt, sext;
    logic        redir, bad, isexc;
    sext  = {{14{off[15]}}, off, 2'b00};
    redir = 1'b1;
    tgt   = m_pc + 32'd4;
    case (op)
      3'd1:    tgt = pd + sext;
      3'd2:    tgt = ab;
      3'd3:    tgt = 32'h4180;
      3'd4:    tgt = m_epc;
      default: redir = 1'b0;
    endcase
    bad   = (op == 3'd1 || op == 3'd2) && (tgt[1:0] != 2'b00);
    isexc = (op == 3'd3) || bad;
    if (bad) tgt = 32'h4180;
    ae = 1'b0;
    if (!s && m_pv) begin
      m_pv = 1'b0;
      if (op == 3'd3) begin
        m_pc  = 32'h4180;
        m_epc = ep;
      end else begin
        m_pc = m_pt;
      end
    end else if (!s) begin
      m_pc = redir ? tgt : m_pc + 32'd4;
      if (isexc) m_epc = bad ? pd - 32'd4 : ep;
      ae = bad;
    end else if (redir && (!m_pv || !m_pexc || isexc)) begin
      m_pv   = 1'b1;
      m_pt   = tgt;
      m_pexc = isexc;
      if (isexc) m_epc = bad ? pd - 32'd4 : ep;
      ae = bad;
    end
  endtask

  // Drive one cycle of stimulus, queue the model's expectation, compare after the edge
  task automatic cycle(input logic s, input logic [2:0] op, input logic [31:0] pd,
                       input logic [15:0] off, input logic [31:0] ab, input logic [31:0] ep);
    exp_t e;
    logic ae;
    stall = s; npcop = op; pcplusD = pd; offset = off; absaddress = ab; exc_pc = ep;
    model_step(s, op, pd, off, ab, ep, ae);
    e.pc = m_pc; e.epc = m_epc; e.pv = m_pv; e.ae = ae;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("sb_pc", pc, e.pc);
    check("sb_pcplus", pcplus, e.pc + 32'd4);
    check("sb_epc", epc, e.epc);
    check("sb_pend_valid", 32'(pend_valid), 32'(e.pv));
    check("sb_addr_err", 32'(addr_err), 32'(e.ae));
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 3'd0, 32'h0, 16'h0, 32'h0, 32'h0);
  endtask

  // Pulse reset between clock edges and verify its immediate effect
  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check("rst_pc", pc, 32'h3000);
    check("rst_pcplus", pcplus, 32'h3004);
    check("rst_epc", epc, 32'h0);
    check("rst_pend_valid", 32'(pend_valid), 32'h0);
    check("rst_addr_err", 32'(addr_err), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; npcop = 3'd0; pcplusD = '0; offset = '0; absaddress = '0; exc_pc = '0;
    model_reset();
    #3;
    check("init_pc", pc, 32'h3000);
    check("init_pend_valid", 32'(pend_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // T1: run a little, reset mid-run, then 3 sequential edges
    repeat (2) idle_cycle();
    pulse_reset();
    repeat (3) idle_cycle();
    check("t1_seq3", pc, 32'h300C);

    // T2: branches, including a wrap
    cycle(1'b0, 3'd1, 32'h3010, 16'hFFFE, 32'h0, 32'h0);
    check("t2_br_neg", pc, 32'h3008);
    cycle(1'b0, 3'd1, 32'h3010, 16'h0004, 32'h0, 32'h0);
    check("t2_br_pos", pc, 32'h3020);
    cycle(1'b0, 3'd1, 32'hFFFF_FFFC, 16'h0001, 32'h0, 32'h0);
    check("t2_br_wrap", pc, 32'h0);

    // T3: exception then eret
    cycle(1'b0, 3'd3, 32'h0, 16'h0, 32'h0, 32'h3040);
    check("t3_exc_pc", pc, 32'h4180);
    check("t3_exc_epc", epc, 32'h3040);
    repeat (2) idle_cycle();
    cycle(1'b0, 3'd4, 32'h0, 16'h0, 32'h0, 32'h0);
    check("t3_eret", pc, 32'h3040);

    // T4: stalled jump applied on release
    cycle(1'b1, 3'd2, 32'h0, 16'h0, 32'h3100, 32'h0);
    check("t4_held", pc, 32'h3040);
    check("t4_pv", 32'(pend_valid), 32'h1);
    repeat (2) cycle(1'b1, 3'd0, 32'h0, 16'h0, 32'h0, 32'h0);
    idle_cycle();
    check("t4_release", pc, 32'h3100);
    check("t4_pv_clr", 32'(pend_valid), 32'h0);
    // pending exception is not displaced by a later stalled jump
    cycle(1'b1, 3'd3, 32'h0, 16'h0, 32'h0, 32'h3200);
    cycle(1'b1, 3'd2, 32'h0, 16'h0, 32'h3300, 32'h0);
    idle_cycle();
    check("t4_exc_wins", pc, 32'h4180);
    check("t4_exc_epc", epc, 32'h3200);
    // exception on the release edge overrides a buffered jump
    cycle(1'b1, 3'd2, 32'h0, 16'h0, 32'h3400, 32'h0);
    cycle(1'b0, 3'd3, 32'h0, 16'h0, 32'h0, 32'h3444);
    check("t4_rel_exc", pc, 32'h4180);
    check("t4_rel_exc_epc", epc, 32'h3444);

    // undefined npcop behaves as sequential
    cycle(1'b0, 3'd6, 32'h0, 16'h0, 32'h5000, 32'h0);
    check("undef_seq", pc, 32'h4184);

    // T5: misaligned jump
    cycle(1'b0, 3'd2, 32'h3020, 16'h0, 32'h3102, 32'h0);
    check("t5_pc", pc, 32'h4180);
    check("t5_epc", epc, 32'h301C);
    check("t5_ae_hi", 32'(addr_err), 32'h1);
    idle_cycle();
    check("t5_ae_lo", 32'(addr_err), 32'h0);

    // T6: reset while a redirect is buffered
    cycle(1'b1, 3'd2, 32'h0, 16'h0, 32'h3500, 32'h0);
    check("t6_pv_set", 32'(pend_valid), 32'h1);
    pulse_reset();
    idle_cycle();
    check("t6_no_stale", pc, 32'h3004);

    // randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ab;
      ab = 32'h3000 + ($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 7) == 0) ab[1:0] = 2'($urandom_range(1, 3));
      cycle(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
            32'h3000 + ($urandom_range(0, 255) << 2) + 32'($urandom_range(0, 15) == 0 ? 2 : 0),
            16'($urandom), ab, 32'h3000 + ($urandom_range(0, 255) << 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
